// File: rtl/conv_window_ctrl.sv
// Purpose : sequences the conv line-buffer chain over one IMG_W x IMG_H raster
//           frame, tracks row/column and flags complete K x K windows.
// Latency : shift_en is combinational with acceptance; win_vld/win_row/win_col
//           follow one cycle after the accepting edge; frame_done in the DONE cycle.
// Backpressure: in_rdy = RUN && out_rdy; without acceptance nothing advances.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               begin a frame (honoured only in IDLE)
//   busy                high in RUN and DONE
//   in_vld / in_rdy     upstream pixel handshake
//   shift_en            line-buffer shift strobe (one per accepted pixel)
//   out_rdy             downstream MAC array can take a window
//   win_vld/win_row/win_col  registered window strobe and top-left position
//   frame_done          one-cycle end-of-frame pulse
//
// Build option: define CONV_WIN_STRIDE2_EN for stride-2 window selection;
// undefined gives stride 1. Shift, counters and FSM are identical in both.
module conv_window_ctrl #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic             shift_en,
   input  logic             out_rdy,
   output logic             win_vld,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] WM1 = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] HM1 = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] row, col;
   logic [CNT_W-1:0] row_off, col_off;
   logic             last_pix;
   logic             win_ok;

   // Offsets from the first valid window position; only meaningful when
   // row/col >= K-1, which win_ok checks first.
   assign row_off  = row - KM1;
   assign col_off  = col - KM1;
   assign last_pix = (row == HM1) && (col == WM1);

   always_comb begin
      win_ok = (row >= KM1) && (col >= KM1);
`ifdef CONV_WIN_STRIDE2_EN
      win_ok = win_ok && !row_off[0] && !col_off[0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      in_rdy     = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy   = 1'b1;
            in_rdy = out_rdy;
            if (in_vld && out_rdy && last_pix) state_nxt = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      shift_en = in_vld && in_rdy;
   end

   // Position counters and the registered window strobe. The last pixel leaves
   // the counters parked at the frame corner; the next start clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row     <= '0;
         col     <= '0;
         win_vld <= 1'b0;
         win_row <= '0;
         win_col <= '0;
      end else begin
         win_vld <= 1'b0;
         if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
         end
         if (shift_en) begin
            if (!last_pix) begin
               if (col == WM1) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            if (win_ok) begin
               win_vld <= 1'b1;
               win_row <= row_off;
               win_col <= col_off;
            end
         end
      end
   end

endmodule
